// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), bout = borrow-out.
// The datapath is a single full-subtractor slice with a borrow flop. It takes
// WIDTH clock edges per operation and processes the operands LSB first.
// The input and output both use valid/ready handshakes.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//
// Ports
//   clk        clock, all state updates on posedge
//   reset_n    asynchronous reset, active-low
//   in_valid   a/b/bin valid
//   in_ready   block idle, can accept an operation
//   a          minuend
//   b          subtrahend
//   bin        borrow-in
//   out_valid  diff/bout valid
//   out_ready  consumer accepts the result
//   diff       a - b - bin, modulo 2^WIDTH
//   bout       1 iff a < b + bin (unsigned)
//   overflow   signed overflow (present only when SERIAL_SUB_OVERFLOW_EN is
//              defined)
//
// Configuration macro
//   SERIAL_SUB_OVERFLOW_EN  adds the overflow port and its register
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // Elaboration-time guard: a zero-width subtractor is meaningless.
  if (WIDTH < 1) begin : g_width_check
    $error("serial_subtractor: WIDTH must be >= 1");
  end

  // The counter must be able to hold WIDTH itself, because it stops there
  // when the block leaves RUN.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CW-1:0]    cnt;       // index of the bit processed on the next edge
  logic [WIDTH-1:0] a_sh;      // minuend, shifted right one bit per RUN edge
  logic [WIDTH-1:0] b_sh;      // subtrahend, shifted in step with a_sh
  logic             brw;       // borrow into the current bit

  logic             accept;
  logic             last_bit;
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             brw_nxt;

  // ---------------------------------------------------------------------------
  // Handshake and full-subtractor slice
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (state == RUN) && (cnt == CW'(WIDTH - 1));

  assign a_bit   = a_sh[0];
  assign b_bit   = b_sh[0];
  assign d_bit   = a_bit ^ b_bit ^ brw;
  assign brw_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block here uses non-blocking assignments, so each
  // register samples values from before the edge. Blocking assignments would
  // make the result depend on the order in which the statements are written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets its default before the case statement. Without it,
  // any path that does not assign state_nxt would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)    state_nxt = RUN;
      RUN:  if (last_bit)  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shift registers, borrow flop, bit counter
  // ---------------------------------------------------------------------------
  // NOTE: the operand registers are cleared on reset even though an accept
  // always loads them first. Clearing them keeps the state after reset fully
  // defined and costs only a handful of flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh <= '0;
      b_sh <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      // The operands are sampled only here. Later changes on a/b/bin are
      // ignored until the next accept.
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      brw  <= brw_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  // Each difference bit enters at the MSB, so after WIDTH shifts bit 0 of the
  // result sits in diff[0]. The cast-and-shift form also works for WIDTH == 1,
  // where a concatenation with diff[WIDTH-1:1] would be an illegal slice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (state == RUN) begin
      diff <= (diff >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
      if (last_bit) begin
        bout <= brw_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Signed overflow is the borrow into the MSB XOR the borrow out of the MSB.
  // On the last RUN edge, brw is exactly the borrow into the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (last_bit) begin
      overflow <= brw ^ brw_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor. It instantiates one WIDTH=16 DUT and
// one WIDTH=1 DUT on a shared clock and reset. Inputs are driven 1 time unit
// after each rising edge, and outputs are sampled at the same point.
// Define SERIAL_SUB_OVERFLOW_EN to also check the overflow output.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;

  // WIDTH=16 DUT signals
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;

  // WIDTH=1 DUT signals
  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         bin1 = 1'b0;
  logic         out_valid1;
  logic         out_ready1 = 1'b0;
  logic [0:0]   diff1;
  logic         bout1;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
  logic         overflow1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) u_dut16 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .diff      (diff1),
    .bout      (bout1)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow  (overflow1)
`endif
  );

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one operation for one edge.
  // After the accepting edge it scrambles the operands, so the result also
  // shows that the DUT sampled them only at acceptance.
  task automatic start16(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_start", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    bin = bv_in;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    bin = ~bv_in;
  endtask

  // Counts edges after acceptance until out_valid goes high (bounded).
  task automatic wait_done16(input string tag);
    int lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd16);
  endtask

  task automatic check_result16(input string tag, input logic [W-1:0] ed,
                                input logic eb, input logic eo);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
`else
    if (eo === 1'bx) check({tag, "_ovf_arg"}, 32'(eo), 32'd0);
`endif
  endtask

  task automatic drain16(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op16(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bv_in, input logic [W-1:0] ed, input logic eb,
                          input logic eo);
    start16(av, bv, bv_in);
    wait_done16(tag);
    check_result16(tag, ed, eb, eo);
    drain16(tag);
  endtask

  // WIDTH=1: expected values come from integer arithmetic, not the bit-level
  // formula. The signed view of a 1-bit value is 0 or -1.
  task automatic run_op1(input logic av, input logic bv, input logic bv_in);
    int r;
    int rs;
    int lat = -1;
    logic ed;
    logic eb;
    logic eo;
    r  = int'(av) - int'(bv) - int'(bv_in);
    rs = -int'(av) + int'(bv) - int'(bv_in);
    ed = r[0];
    eb = (r < 0);
    eo = (rs < -1) || (rs > 0);
    a1 = av;
    b1 = bv;
    bin1 = bv_in;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (out_valid1) begin
        lat = k;
        break;
      end
    end
    check($sformatf("w1_%0d%0d%0d_latency", av, bv, bv_in), 32'(lat), 32'd1);
    check($sformatf("w1_%0d%0d%0d_diff", av, bv, bv_in), 32'(diff1), 32'(ed));
    check($sformatf("w1_%0d%0d%0d_bout", av, bv, bv_in), 32'(bout1), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check($sformatf("w1_%0d%0d%0d_ovf", av, bv, bv_in), 32'(overflow1), 32'(eo));
`else
    if (eo === 1'bx) check("w1_ovf_arg", 32'(eo), 32'd0);
`endif
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("w1_in_ready_after", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    // Reset state, sampled while reset is asserted
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", 32'(overflow), 32'd0);
`endif
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Basic operations with hand-computed results
    run_op16("t1_5m3",       16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op16("t2_0m1",       16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op16("t2_bin",       16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0);
    run_op16("bin_only",     16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op16("equal_max",    16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_op16("ovf_neg",      16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op16("ovf_pos",      16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Backpressure: the result must hold and new requests must be refused.
    start16(16'h00FF, 16'h0100, 1'b0);
    wait_done16("bp");
    check_result16("bp", 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = 16'h0003;
      b = 16'h0001;
      bin = 1'b0;
      in_valid = 1'b1;
      tick();
      check("bp_hold_diff", 32'(diff), 32'h0000FFFF);
      check("bp_hold_bout", 32'(bout), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    drain16("bp");
    run_op16("bp_next",      16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);

    // Asynchronous reset in the middle of RUN
    start16(16'hFFFF, 16'h0001, 1'b0);
    repeat (7) tick();
    check("mid_out_valid_pre", 32'(out_valid), 32'd0);
    check("mid_in_ready_pre", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_diff", 32'(diff), 32'd0);
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_op16("post_rst_9m4", 16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0);
    run_op16("small_5m3",    16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    // WIDTH=1: every input combination
    check("w1_in_ready_idle", 32'(in_ready1), 32'd1);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] t;
      t = 3'(v);
      run_op1(t[2], t[1], t[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
